fetch_buffer: RTL

- Instruction-side prefetch unit directly upstream of the core's fetch stage.
- Consumes the core's PC output. Produces the core's instruction word and instruction-valid inputs.
- Drives a pipelined, in-order, variable-latency instruction-memory bus.
- Prefetches sequential words into a small FIFO tagged with addresses, so the core sees a same-cycle, LUT-cache-like instruction port.

---
 rtl/fetch_buffer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Sequential instruction prefetcher: keeps a small address-tagged FIFO ahead of the
// core PC and fills it from a pipelined, in-order, variable-latency read bus.
module fetch_buffer #(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] PC_START        = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_instr,
    output logic            o_ifValid,
    output logic            o_busReq,
    output logic [XLEN-1:0] o_busAddr,
    input  logic            i_busGnt,
    input  logic            i_busRvalid,
    input  logic [XLEN-1:0] i_busRdata
);

    localparam int WA  = XLEN - 2;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int OCW = CW + 1;
    localparam int QW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

    // Addresses are held as word addresses; the byte offset never takes part in a compare.
    logic [WA-1:0]   fifo_addr [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [WA-1:0]   tag_q     [MAX_OUTSTANDING];

    logic [PW-1:0]  rd_ptr, wr_ptr, rd_ptr1;
    logic [CW-1:0]  count;
    logic [WA-1:0]  req_word;
    logic [QW-1:0]  tag_rd, tag_wr, live_idx;
    logic [OW-1:0]  outstanding, drop_cnt, out_next;
    logic [OCW-1:0] occ;

    logic [WA-1:0] pc_word, head_next;
    logic          hit0, adv, adv_hit, live_pending, wait_empty, redirect;
    logic          gnt, rsp, push;
    logic          unused_pc_bits;

    function automatic logic [QW-1:0] inc_q(input logic [QW-1:0] q);
        return (q == QW'(MAX_OUTSTANDING - 1)) ? '0 : q + QW'(1);
    endfunction

    assign pc_word        = i_pc[XLEN-1:2];
    assign unused_pc_bits = ^i_pc[1:0];
    assign rd_ptr1        = rd_ptr + PW'(1);
    assign head_next      = fifo_addr[rd_ptr] + WA'(1);

    assign hit0    = (count != '0) && (fifo_addr[rd_ptr] == pc_word);
    assign adv     = (count != '0) && (head_next == pc_word);
    assign adv_hit = adv && (count >= CW'(2)) && (fifo_addr[rd_ptr1] == pc_word);

    // The first response that will actually land in the FIFO skips the ones marked for drop.
    assign live_idx     = QW'((32'(tag_rd) + 32'(drop_cnt)) % MAX_OUTSTANDING);
    assign live_pending = outstanding > drop_cnt;
    assign wait_empty   = (count == '0) &&
                          ((req_word == pc_word) || (live_pending && (tag_q[live_idx] == pc_word)));
    assign redirect     = !(hit0 || adv || wait_empty);

    assign occ       = OCW'(count) + OCW'(outstanding) - OCW'(drop_cnt);
    assign o_busReq  = !i_rst && !redirect && (occ < OCW'(DEPTH)) &&
                       (outstanding < OW'(MAX_OUTSTANDING));
    assign o_busAddr = {req_word, 2'b00};

    assign gnt      = o_busReq && i_busGnt;
    assign rsp      = i_busRvalid && (outstanding != '0);
    assign push     = rsp && (drop_cnt == '0) && !redirect;
    assign out_next = outstanding + OW'(gnt) - OW'(rsp);

    always_comb begin
        o_ifValid = 1'b0;
        o_instr   = '0;
        if (hit0) begin
            o_ifValid = 1'b1;
            o_instr   = fifo_data[rd_ptr];
        end else if (adv_hit) begin
            o_ifValid = 1'b1;
            o_instr   = fifo_data[rd_ptr1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            req_word    <= PC_START[XLEN-1:2];
            tag_rd      <= '0;
            tag_wr      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= out_next;
            if (gnt) begin
                req_word <= req_word + WA'(1);
                tag_wr   <= inc_q(tag_wr);
            end
            if (rsp)
                tag_rd <= inc_q(tag_rd);
            // Everything still in flight after this cycle belongs to the old stream.
            if (redirect) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                req_word <= pc_word;
                drop_cnt <= out_next;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (adv)
                    rd_ptr <= rd_ptr1;
                count <= count + CW'(push) - CW'(adv);
                if (rsp && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - OW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= tag_q[tag_rd];
            fifo_data[wr_ptr] <= i_busRdata;
        end
        if (gnt)
            tag_q[tag_wr] <= req_word;
    end

    rvalid_needs_outstanding: assert property (
        @(posedge i_clk) disable iff (i_rst) i_busRvalid |-> (outstanding != '0));

endmodule
